// File: rtl/risc_intc_pkg.sv
// risc_intc_pkg: shared constants, state encoding and vector helper for the interrupt controller
package risc_intc_pkg;
  localparam int VEC_W = 16;
  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_INSV = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;
  typedef enum logic {IDLE, REQ} state_t;
  function automatic logic [VEC_W-1:0] vec_addr(input logic [VEC_W-1:0] base, input int stride, input logic [3:0] id);
    return VEC_W'(32'(base) + 32'(id) * 32'(stride));
  endfunction
endpackage

// File: rtl/risc_intc_if.sv
// risc_intc_if: CPU-side register port and interrupt handshake of the interrupt controller
interface risc_intc_if;
  import risc_intc_pkg::*;
  logic             reg_we;
  logic [1:0]       reg_addr;
  logic [15:0]      reg_wdata;
  logic [15:0]      reg_rdata;
  logic             int_ack;
  logic             int_eoi;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic [3:0]       int_id;
  modport master (output reg_we, reg_addr, reg_wdata, int_ack, int_eoi,
                  input  reg_rdata, int_req, int_vec, int_id);
  modport slave  (input  reg_we, reg_addr, reg_wdata, int_ack, int_eoi,
                  output reg_rdata, int_req, int_vec, int_id);
endinterface

// File: rtl/risc_intc_prio.sv
// risc_intc_prio: find-first-set encoder, lowest set index wins
module risc_intc_prio #(
  parameter int W = 8
) (
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);
  // scan from the top so the lowest set bit is written last
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) idx = req[i] ? 4'(i) : idx;
  end
endmodule

// File: rtl/risc_intc.sv
// risc_intc: prioritised, nestable interrupt controller with edge/level channels
module risc_intc
  import risc_intc_pkg::*;
#(
  parameter int                 NUM_IRQ    = 8,
  parameter logic [VEC_W-1:0]   VEC_BASE   = 16'h0010,
  parameter int                 VEC_STRIDE = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK  = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  risc_intc_if.slave         bus
);
  localparam logic [NUM_IRQ-1:0] LO8 = NUM_IRQ'(16'h00FF);
  logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d, mask_q, mask_d, insv_q, insv_d, mode_q, mode_d;
  logic               gie_q, gie_d;
  state_t             state_q, state_d;
  logic [3:0]         id_q, id_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_IRQ-1:0] rise, hi_mask, elig, id_oh, ins_oh, set_oh;
  logic               elig_any, ins_valid, ack_ok, still_ok;
  logic [3:0]         win_idx, ins_idx;
  logic               wr_mask, wr_pend, wr_ctrl;
  logic [7:0]         mode8;

  risc_intc_prio #(.W(NUM_IRQ)) u_win (.req(elig),   .valid(elig_any),  .idx(win_idx));
  risc_intc_prio #(.W(NUM_IRQ)) u_ins (.req(insv_q), .valid(ins_valid), .idx(ins_idx));

  assign rise     = sync2_q & ~hist_q;
  assign hi_mask  = ins_valid ? NUM_IRQ'((32'd1 << ins_idx) - 32'd1) : '1;
  assign elig     = pend_q & mask_q & hi_mask;
  assign id_oh    = NUM_IRQ'(32'd1 << id_q);
  assign ins_oh   = ins_valid ? NUM_IRQ'(32'd1 << ins_idx) : '0;
  assign ack_ok   = (state_q == REQ) && bus.int_ack;
  assign still_ok = gie_q && |(elig & id_oh);
  assign set_oh   = ack_ok ? id_oh : '0;
  assign wr_mask  = bus.reg_we && bus.reg_addr == ADDR_MASK;
  assign wr_pend  = bus.reg_we && bus.reg_addr == ADDR_PEND;
  assign wr_ctrl  = bus.reg_we && bus.reg_addr == ADDR_CTRL;
  assign mode8    = 8'(mode_q);

  assign bus.reg_rdata = bus.reg_addr == ADDR_MASK ? 16'(mask_q) :
                         bus.reg_addr == ADDR_PEND ? 16'(pend_q) :
                         bus.reg_addr == ADDR_INSV ? 16'(insv_q) :
                         {mode8, 7'b0, gie_q};
  assign bus.int_req = state_q == REQ;
  assign bus.int_id  = id_q;
  assign bus.int_vec = vec_q;

  // next-state for synchronisers, registers and in-service tracking; hardware sets beat clears
  always_comb begin
    sync1_d = irq;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    pend_d  = (mode_q & ((pend_q & ~((wr_pend ? NUM_IRQ'(bus.reg_wdata) : '0) | set_oh)) | rise))
            | (~mode_q & sync2_q);
    insv_d  = (insv_q & ~(bus.int_eoi ? ins_oh : '0)) | set_oh;
    mask_d  = wr_mask ? NUM_IRQ'(bus.reg_wdata) : mask_q;
    gie_d   = wr_ctrl ? bus.reg_wdata[0] : gie_q;
    mode_d  = wr_ctrl ? (mode_q & ~LO8) | (NUM_IRQ'(bus.reg_wdata[15:8]) & LO8) : mode_q;
  end

  // request FSM: latch the winner in IDLE, hold it in REQ until ack or withdrawal
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    if (state_q == IDLE) begin
      state_d = gie_q && elig_any ? REQ : IDLE;
      id_d    = gie_q && elig_any ? win_idx : id_q;
      vec_d   = gie_q && elig_any ? vec_addr(VEC_BASE, VEC_STRIDE, win_idx) : vec_q;
    end else begin
      state_d = ack_ok || !still_ok ? IDLE : REQ;
    end
  end

  // state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      insv_q  <= '0;
      mode_q  <= EDGE_MASK;
      gie_q   <= 1'b0;
      state_q <= IDLE;
      id_q    <= '0;
      vec_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      insv_q  <= insv_d;
      mode_q  <= mode_d;
      gie_q   <= gie_d;
      state_q <= state_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end
endmodule

// File: tb/tb_risc_intc.sv
// tb_risc_intc: directed vector table plus hand-written corner sequences for risc_intc
module tb_risc_intc;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] irq = '0;
  int         n_cmp = 0;
  int         n_bad = 0;

  risc_intc_if bus();
  risc_intc u_dut (.clk(clk), .reset(reset), .irq(irq), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        ack;
    logic        eoi;
    logic        req;
    logic [3:0]  id;
    logic [15:0] vec;
    logic [15:0] rd;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.reg_we = 1'b1;
    bus.reg_addr = a;
    bus.reg_wdata = d;
    tick();
    bus.reg_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [15:0] exp);
    bus.reg_addr = a;
    #1;
    chk(name, bus.reg_rdata, exp);
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.int_eoi = 1'b1;
    tick();
    bus.int_eoi = 1'b0;
  endtask

  task automatic wait_req(input string name, input int n);
    int c = 0;
    while (!bus.int_req && c < n) begin
      tick();
      c++;
    end
    chk(name, 16'(bus.int_req), 16'd1);
  endtask

  task automatic wait_drop(input string name, input int n);
    int c = 0;
    while (bus.int_req && c < n) begin
      tick();
      c++;
    end
    chk(name, 16'(bus.int_req), 16'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req"}, 16'(bus.int_req), 16'd0);
    chk({tag, " id"}, 16'(bus.int_id), 16'd0);
    chk({tag, " vec"}, bus.int_vec, 16'h0000);
    rd({tag, " MASK"}, 2'd0, 16'h0000);
    rd({tag, " PEND"}, 2'd1, 16'h0000);
    rd({tag, " INSV"}, 2'd2, 16'h0000);
    rd({tag, " CTRL"}, 2'd3, 16'hFF00);
  endtask

  initial begin
    bus.reg_we = 1'b0;
    bus.reg_addr = 2'd0;
    bus.reg_wdata = '0;
    bus.int_ack = 1'b0;
    bus.int_eoi = 1'b0;
    //              irq    we    addr  wdata     ack   eoi   req   id    vec       rd
    tbl[0]  = '{8'h00, 1'b1, 2'd0, 16'h0009, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0009};
    tbl[1]  = '{8'h00, 1'b1, 2'd3, 16'hFF01, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'hFF01};
    tbl[2]  = '{8'h08, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[3]  = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000};
    tbl[4]  = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0008};
    tbl[5]  = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd3, 16'h001C, 16'h0008};
    tbl[6]  = '{8'h00, 1'b0, 2'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd3, 16'h001C, 16'h0008};
    tbl[7]  = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h001C, 16'h0000};
    tbl[8]  = '{8'h01, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h001C, 16'h0000};
    tbl[9]  = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h001C, 16'h0000};
    tbl[10] = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3, 16'h001C, 16'h0001};
    tbl[11] = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0010, 16'h0001};
    tbl[12] = '{8'h00, 1'b0, 2'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0010, 16'h0009};
    tbl[13] = '{8'h00, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0010, 16'h0008};
    tbl[14] = '{8'h00, 1'b1, 2'd0, 16'h0029, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0010, 16'h0029};
    tbl[15] = '{8'h20, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0010, 16'h0000};
    tbl[16] = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0010, 16'h0000};
    tbl[17] = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0010, 16'h0020};
    tbl[18] = '{8'h00, 1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0010, 16'h0020};
    tbl[19] = '{8'h00, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd0, 16'h0010, 16'h0000};
    tbl[20] = '{8'h00, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 4'd5, 16'h0024, 16'h0000};
    tbl[21] = '{8'h00, 1'b0, 2'd2, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd5, 16'h0024, 16'h0020};
    tbl[22] = '{8'h00, 1'b0, 2'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd5, 16'h0024, 16'h0000};

    repeat (2) tick();
    chk_reset("reset");
    reset = 1'b1;
    tick();

    for (int k = 0; k < 23; k++) begin
      irq = tbl[k].irq;
      bus.reg_we = tbl[k].we;
      bus.reg_addr = tbl[k].addr;
      bus.reg_wdata = tbl[k].wdata;
      bus.int_ack = tbl[k].ack;
      bus.int_eoi = tbl[k].eoi;
      tick();
      bus.reg_we = 1'b0;
      bus.int_ack = 1'b0;
      bus.int_eoi = 1'b0;
      chk($sformatf("row%0d req", k), 16'(bus.int_req), 16'(tbl[k].req));
      chk($sformatf("row%0d id", k), 16'(bus.int_id), 16'(tbl[k].id));
      chk($sformatf("row%0d vec", k), bus.int_vec, tbl[k].vec);
      chk($sformatf("row%0d rdata", k), bus.reg_rdata, tbl[k].rd);
    end

    // level channel 2: re-request after eoi, withdraw when the line drops
    wr(2'd3, 16'hFB01);
    wr(2'd0, 16'h0004);
    rd("level CTRL", 2'd3, 16'hFB01);
    irq = 8'h04;
    wait_req("level req", 8);
    chk("level id", 16'(bus.int_id), 16'd2);
    chk("level vec", bus.int_vec, 16'h0018);
    pulse_ack();
    rd("level INSV", 2'd2, 16'h0004);
    rd("level PEND kept", 2'd1, 16'h0004);
    repeat (3) tick();
    chk("level self block", 16'(bus.int_req), 16'd0);
    pulse_eoi();
    wait_req("level rereq", 4);
    chk("level rereq id", 16'(bus.int_id), 16'd2);
    irq = 8'h00;
    wait_drop("level withdraw", 4);
    rd("level PEND drop", 2'd1, 16'h0000);
    rd("level INSV none", 2'd2, 16'h0000);

    // masking withdraws the request; an ack on the withdrawal cycle still wins
    wr(2'd3, 16'hFF01);
    wr(2'd0, 16'h0008);
    irq = 8'h08;
    tick();
    irq = 8'h00;
    wait_req("mask req", 8);
    chk("mask id", 16'(bus.int_id), 16'd3);
    wr(2'd0, 16'h0000);
    tick();
    chk("mask withdraw", 16'(bus.int_req), 16'd0);
    rd("mask PEND kept", 2'd1, 16'h0008);
    wr(2'd0, 16'h0008);
    wait_req("mask rereq", 4);
    wr(2'd0, 16'h0000);
    pulse_ack();
    chk("ack wins req", 16'(bus.int_req), 16'd0);
    rd("ack wins INSV", 2'd2, 16'h0008);
    rd("ack wins PEND", 2'd1, 16'h0000);

    // asynchronous reset in the middle of a request with a handler in service
    wr(2'd0, 16'h0001);
    irq = 8'h01;
    tick();
    irq = 8'h00;
    wait_req("pre-reset req", 8);
    chk("pre-reset id", 16'(bus.int_id), 16'd0);
    rd("pre-reset INSV", 2'd2, 16'h0008);
    #1;
    reset = 1'b0;
    #1;
    chk_reset("async reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
